// File: rtl/campus_env_gen_if.sv
// Status bundle between the campus environment generator and the schedule FSM.
// master: generator side (samples state_in, drives every status signal).
// slave:  FSM / testbench side (drives state_in, samples status and calendar).
interface campus_env_gen_if;
    logic [4:0] state_in;
    logic       alarm;
    logic       bus;
    logic       hungry;
    logic       lecture;
    logic       tired;
    logic       homework;
    logic       design_work;
    logic       brain_no_work;
    logic       energy;
    logic [3:0] num_assignments;
    logic [3:0] num_lectures;
    logic [4:0] hour;
    logic [2:0] day;

    modport master (
        input  state_in,
        output alarm, bus, hungry, lecture, tired, homework, design_work,
               brain_no_work, energy, num_assignments, num_lectures, hour, day
    );

    modport slave (
        output state_in,
        input  alarm, bus, hungry, lecture, tired, homework, design_work,
               brain_no_work, energy, num_assignments, num_lectures, hour, day
    );
endinterface

// File: rtl/campus_env_gen.sv
// Purpose: closes the loop around the student schedule FSM by generating its status inputs from a calendar and activity counters.
// Latency: counter-based outputs reflect state_in one edge later; alarm, lecture, design_work are combinational from registers (+ state_in).
// Backpressure: none; free-running, samples state_in on every rising clk edge.
// Ports: clk, rst (async, active-high), env (master modport: state_in in, status/calendar out).
module campus_env_gen #(
    parameter int TICKS_PER_HOUR = 4,
    parameter int WAKE_HOUR      = 7,
    parameter int BUS_PERIOD     = 3,
    parameter int HUNGER_LIMIT   = 12,
    parameter int AWAKE_LIMIT    = 64,
    parameter int ENERGY_MAX     = 15,
    parameter int DESIGN_TICKS   = 8,
    parameter int BRAIN_LIMIT    = 20
) (
    input  logic              clk,
    input  logic              rst,
    campus_env_gen_if.master  env
);
    localparam int TW = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
    localparam int BW = $clog2(BUS_PERIOD);

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_HOUR - 1);
    localparam logic [BW-1:0] BUS_LAST    = BW'(BUS_PERIOD - 1);
    localparam logic [4:0]    WAKE        = 5'(WAKE_HOUR);
    localparam logic [7:0]    HUNGER_MAX  = 8'(HUNGER_LIMIT);
    localparam logic [7:0]    AWAKE_MAX   = 8'(AWAKE_LIMIT);
    localparam logic [3:0]    ENERGY_FULL = 4'(ENERGY_MAX);
    localparam logic [7:0]    DESIGN_LAST = 8'(DESIGN_TICKS - 1);
    localparam logic [7:0]    BRAIN_MAX   = 8'(BRAIN_LIMIT);

    localparam logic [4:0] ST_SLEEP   = 5'd0;
    localparam logic [4:0] ST_EAT     = 5'd1;
    localparam logic [4:0] ST_LECTURE = 5'd3;
    localparam logic [4:0] ST_STUDY   = 5'd5;
    localparam logic [4:0] ST_DESIGN  = 5'd6;
    localparam logic [4:0] ST_GYM     = 5'd8;

    logic [TW-1:0] tick;
    logic [4:0]    hour;
    logic [2:0]    day;
    logic [BW-1:0] bus_cnt;
    logic [7:0]    hunger_cnt;
    logic [7:0]    awake_cnt;
    logic [3:0]    energy_cnt;
    logic [7:0]    design_cnt;
    logic [7:0]    brain_cnt;
    logic [4:0]    prev_state;
    logic          woke_today;
    logic          lecture_done;
    logic          design_done;
    logic          homework;
    logic [3:0]    num_lectures;
    logic [3:0]    num_assignments;

    logic          tick_wrap;
    logic          midnight;
    logic [2:0]    next_day;
    logic          next_weekday;
    logic          brain_state;

    assign tick_wrap    = (tick == TICK_LAST);
    assign midnight     = tick_wrap && (hour == 5'd23);
    assign next_day     = (day == 3'd6) ? 3'd0 : day + 3'd1;
    assign next_weekday = (next_day < 3'd5);
    assign brain_state  = (env.state_in == ST_LECTURE) || (env.state_in == ST_STUDY) ||
                          (env.state_in == ST_DESIGN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick            <= '0;
            hour            <= 5'd0;
            day             <= 3'd0;
            bus_cnt         <= '0;
            hunger_cnt      <= 8'd0;
            awake_cnt       <= 8'd0;
            energy_cnt      <= ENERGY_FULL;
            design_cnt      <= 8'd0;
            brain_cnt       <= 8'd0;
            prev_state      <= ST_SLEEP;
            woke_today      <= 1'b0;
            lecture_done    <= 1'b0;
            design_done     <= 1'b0;
            homework        <= 1'b1;
            num_lectures    <= 4'd2;   // day 0 workload
            num_assignments <= 4'd3;
        end else begin
            // Calendar
            tick <= tick_wrap ? '0 : tick + 1'b1;
            if (tick_wrap) begin
                hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end
            if (midnight) begin
                day             <= next_day;
                num_lectures    <= next_weekday ? {1'b0, next_day} + 4'd2 : 4'd0;
                num_assignments <= next_weekday ? 4'd3 : 4'd1;
            end

            bus_cnt <= (bus_cnt == BUS_LAST) ? '0 : bus_cnt + 1'b1;

            if (env.state_in == ST_EAT)       hunger_cnt <= 8'd0;
            else if (hunger_cnt != HUNGER_MAX) hunger_cnt <= hunger_cnt + 8'd1;

            if (env.state_in == ST_SLEEP)     awake_cnt <= 8'd0;
            else if (awake_cnt != AWAKE_MAX)   awake_cnt <= awake_cnt + 8'd1;

            if (env.state_in == ST_SLEEP)                      energy_cnt <= ENERGY_FULL;
            else if (env.state_in == ST_GYM && energy_cnt != 4'd0) energy_cnt <= energy_cnt - 4'd1;

            // Run length of uninterrupted DESIGN_TEAM cycles; deliberately not reset at midnight
            if (env.state_in == ST_DESIGN) begin
                if (design_cnt != 8'hFF) design_cnt <= design_cnt + 8'd1;
            end else begin
                design_cnt <= 8'd0;
            end

            prev_state <= env.state_in;

            // Daily flags: the midnight reload takes priority over any same-edge event
            if (midnight) begin
                homework     <= 1'b1;
                lecture_done <= 1'b0;
                woke_today   <= 1'b0;
                brain_cnt    <= 8'd0;
                design_done  <= 1'b0;
            end else begin
                if (env.state_in != ST_SLEEP && hour >= WAKE)
                    woke_today <= 1'b1;
                if (prev_state == ST_LECTURE && env.state_in != ST_LECTURE)
                    lecture_done <= 1'b1;
                if (prev_state == ST_STUDY && env.state_in != ST_STUDY)
                    homework <= 1'b0;
                if (env.state_in == ST_DESIGN && design_cnt == DESIGN_LAST)
                    design_done <= 1'b1;
                if (brain_state && brain_cnt != BRAIN_MAX)
                    brain_cnt <= brain_cnt + 8'd1;
            end
        end
    end

    assign env.alarm           = (env.state_in == ST_SLEEP) && (hour >= WAKE) && !woke_today;
    assign env.bus             = (bus_cnt == BUS_LAST);
    assign env.hungry          = (hunger_cnt == HUNGER_MAX);
    assign env.tired           = (awake_cnt == AWAKE_MAX);
    assign env.energy          = (energy_cnt != 4'd0);
    assign env.lecture         = (day < 3'd5) && !lecture_done && (hour < 5'd12);
    assign env.homework        = homework;
    assign env.design_work     = ((day == 3'd1) || (day == 3'd3)) && !design_done;
    assign env.brain_no_work   = (brain_cnt == BRAIN_MAX);
    assign env.num_lectures    = num_lectures;
    assign env.num_assignments = num_assignments;
    assign env.hour            = hour;
    assign env.day             = day;
endmodule

// File: tb/tb_campus_env_gen.sv
// Bench for campus_env_gen: directed state sequences against a calendar/event model,
// plus literal expectations at the points of interest.
module tb_campus_env_gen;
    localparam int TPH = 4, WAKE = 7, BUSP = 3, HLIM = 12, ALIM = 64;
    localparam int EMAX = 15, DTICKS = 8, BLIM = 20;
    localparam int SLEEP = 0, EAT = 1, BUS = 2, LECTURE = 3, STUDY = 5;
    localparam int DESIGN = 6, NETFLIX = 7, GYM = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    campus_env_gen_if env();

    campus_env_gen #(
        .TICKS_PER_HOUR(TPH), .WAKE_HOUR(WAKE), .BUS_PERIOD(BUSP),
        .HUNGER_LIMIT(HLIM), .AWAKE_LIMIT(ALIM), .ENERGY_MAX(EMAX),
        .DESIGN_TICKS(DTICKS), .BRAIN_LIMIT(BLIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .env (env)
    );

    always #5 clk = ~clk;

    // Model: edges since reset plus per-day event history
    int m_n, m_since_eat, m_since_sleep, m_gym, m_dsg_run, m_brain, m_prev;
    bit m_woke, m_lect_done, m_hw_done, m_dsg_done;
    int u_s, u_pre_hour;
    bit u_mid;
    logic last_bus;

    task automatic model_reset();
        m_n = 0; m_since_eat = 0; m_since_sleep = 0; m_gym = 0;
        m_dsg_run = 0; m_brain = 0; m_prev = SLEEP;
        m_woke = 0; m_lect_done = 0; m_hw_done = 0; m_dsg_done = 0;
        last_bus = 1'b0;
    endtask

    function automatic int m_hour(); return (m_n / TPH) % 24; endfunction
    function automatic int m_day();  return (m_n / (TPH * 24)) % 7; endfunction
    function automatic bit m_wkday(); return m_day() < 5; endfunction

    always @(posedge clk) begin
        if (!rst) begin
            u_s        = int'(env.state_in);
            u_mid      = ((m_n + 1) % (TPH * 24)) == 0;
            u_pre_hour = m_hour();
            if (u_mid) begin
                m_woke = 0; m_lect_done = 0; m_hw_done = 0; m_dsg_done = 0; m_brain = 0;
            end else begin
                if (u_s != SLEEP && u_pre_hour >= WAKE) m_woke = 1;
                if (m_prev == LECTURE && u_s != LECTURE) m_lect_done = 1;
                if (m_prev == STUDY && u_s != STUDY) m_hw_done = 1;
                if (u_s == DESIGN && m_dsg_run + 1 >= DTICKS) m_dsg_done = 1;
                if (u_s == LECTURE || u_s == STUDY || u_s == DESIGN) m_brain++;
            end
            m_dsg_run     = (u_s == DESIGN) ? m_dsg_run + 1 : 0;
            m_since_eat   = (u_s == EAT) ? 0 : m_since_eat + 1;
            m_since_sleep = (u_s == SLEEP) ? 0 : m_since_sleep + 1;
            m_gym         = (u_s == SLEEP) ? 0 : ((u_s == GYM) ? m_gym + 1 : m_gym);
            m_prev        = u_s;
            m_n++;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t edge=%0d)", nm, act, exp, $time, m_n);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            cmp("alarm", 32'(env.alarm), 32'(env.state_in == SLEEP && m_hour() >= WAKE && !m_woke));
            cmp("bus", 32'(env.bus), 32'((m_n % BUSP) == BUSP - 1));
            cmp("bus_consecutive", 32'(last_bus && env.bus), 32'd0);
            cmp("hungry", 32'(env.hungry), 32'(m_since_eat >= HLIM));
            cmp("tired", 32'(env.tired), 32'(m_since_sleep >= ALIM));
            cmp("energy", 32'(env.energy), 32'(m_gym < EMAX));
            cmp("lecture", 32'(env.lecture), 32'(m_wkday() && !m_lect_done && m_hour() < 12));
            cmp("homework", 32'(env.homework), 32'(!m_hw_done));
            cmp("design_work", 32'(env.design_work),
                32'((m_day() == 1 || m_day() == 3) && !m_dsg_done));
            cmp("brain_no_work", 32'(env.brain_no_work), 32'(m_brain >= BLIM));
            cmp("num_lectures", 32'(env.num_lectures), 32'(m_wkday() ? m_day() + 2 : 0));
            cmp("num_assignments", 32'(env.num_assignments), 32'(m_wkday() ? 3 : 1));
            cmp("hour", 32'(env.hour), 32'(m_hour()));
            cmp("day", 32'(env.day), 32'(m_day()));
            last_bus = env.bus;
        end
    end

    // Hold state s for k edges; returns at posedge+1 with state_in still s
    task automatic step(input int s, input int k);
        for (int i = 0; i < k; i++) begin
            env.state_in = 5'(s);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_until(input int s, input int target);
        int guard;
        guard = 0;
        while (m_n < target && guard < 2000) begin
            step(s, 1);
            guard++;
        end
        cmp("run_until_reached", 32'(m_n), 32'(target));
    endtask

    task automatic chk_reset_vals(input string tag);
        cmp({tag, "_alarm"}, 32'(env.alarm), 32'd0);
        cmp({tag, "_bus"}, 32'(env.bus), 32'd0);
        cmp({tag, "_hungry"}, 32'(env.hungry), 32'd0);
        cmp({tag, "_tired"}, 32'(env.tired), 32'd0);
        cmp({tag, "_lecture"}, 32'(env.lecture), 32'd1);
        cmp({tag, "_homework"}, 32'(env.homework), 32'd1);
        cmp({tag, "_design_work"}, 32'(env.design_work), 32'd0);
        cmp({tag, "_brain_no_work"}, 32'(env.brain_no_work), 32'd0);
        cmp({tag, "_energy"}, 32'(env.energy), 32'd1);
        cmp({tag, "_num_lectures"}, 32'(env.num_lectures), 32'd2);
        cmp({tag, "_num_assignments"}, 32'(env.num_assignments), 32'd3);
        cmp({tag, "_hour"}, 32'(env.hour), 32'd0);
        cmp({tag, "_day"}, 32'(env.day), 32'd0);
    endtask

    initial begin
        env.state_in = 5'(SLEEP);
        model_reset();
        #12;
        chk_reset_vals("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Wake-up: hour 7 after 28 edges, bus pulses on edges 2, 5
        for (int i = 1; i <= 28; i++) begin
            step(SLEEP, 1);
            if (i == 2)  cmp("bus_edge2", 32'(env.bus), 32'd1);
            if (i == 3)  cmp("bus_edge3", 32'(env.bus), 32'd0);
            if (i == 5)  cmp("bus_edge5", 32'(env.bus), 32'd1);
            if (i == 27) cmp("alarm_hour6", 32'(env.alarm), 32'd0);
        end
        cmp("hour_after28", 32'(env.hour), 32'd7);
        cmp("alarm_hour7", 32'(env.alarm), 32'd1);
        env.state_in = 5'(EAT);
        #1 cmp("alarm_same_cycle", 32'(env.alarm), 32'd0);
        step(EAT, 1);
        step(SLEEP, 3);
        cmp("alarm_after_woke", 32'(env.alarm), 32'd0);

        // Hunger
        step(EAT, 1);
        step(BUS, 11); cmp("hungry_11", 32'(env.hungry), 32'd0);
        step(BUS, 1);  cmp("hungry_12", 32'(env.hungry), 32'd1);
        step(BUS, 3);  cmp("hungry_hold", 32'(env.hungry), 32'd1);
        step(EAT, 1);  cmp("hungry_eat", 32'(env.hungry), 32'd0);
        step(BUS, 11); cmp("hungry_re11", 32'(env.hungry), 32'd0);
        step(BUS, 1);  cmp("hungry_re12", 32'(env.hungry), 32'd1);

        // Energy
        step(GYM, 14);  cmp("energy_14", 32'(env.energy), 32'd1);
        step(GYM, 1);   cmp("energy_15", 32'(env.energy), 32'd0);
        step(GYM, 2);   cmp("energy_sat", 32'(env.energy), 32'd0);
        step(SLEEP, 1); cmp("energy_sleep", 32'(env.energy), 32'd1);

        // Sleep through midnight: alarm stays off until hour 7 of day 1
        run_until(SLEEP, 95);
        cmp("alarm_h23", 32'(env.alarm), 32'd0);
        run_until(SLEEP, 123);
        cmp("alarm_d1_h6", 32'(env.alarm), 32'd0);
        step(SLEEP, 1);
        cmp("alarm_d1_h7", 32'(env.alarm), 32'd1);
        cmp("day_1", 32'(env.day), 32'd1);

        // Tuesday: lecture, design, brain, homework
        cmp("lecture_d1", 32'(env.lecture), 32'd1);
        cmp("design_work_d1", 32'(env.design_work), 32'd1);
        step(LECTURE, 1);
        step(EAT, 1);   cmp("lecture_done", 32'(env.lecture), 32'd0);
        step(DESIGN, 5);
        step(EAT, 1);
        step(DESIGN, 5); cmp("design_interrupted", 32'(env.design_work), 32'd1);
        step(EAT, 1);
        step(DESIGN, 7); cmp("design_7", 32'(env.design_work), 32'd1);
        step(DESIGN, 1); cmp("design_8", 32'(env.design_work), 32'd0);
        cmp("brain_19", 32'(env.brain_no_work), 32'd0);
        step(STUDY, 1);  cmp("brain_20", 32'(env.brain_no_work), 32'd1);
        step(EAT, 1);    cmp("homework_done", 32'(env.homework), 32'd0);

        // Tired
        step(SLEEP, 1);
        step(NETFLIX, 63); cmp("tired_63", 32'(env.tired), 32'd0);
        step(NETFLIX, 1);  cmp("tired_64", 32'(env.tired), 32'd1);

        // Lecture exit colliding with midnight day 3 -> 4
        run_until(NETFLIX, 382);
        step(LECTURE, 1);
        step(EAT, 1);
        cmp("mid34_day", 32'(env.day), 32'd4);
        cmp("mid34_hour", 32'(env.hour), 32'd0);
        cmp("mid34_lecture", 32'(env.lecture), 32'd1);
        cmp("mid34_num_lectures", 32'(env.num_lectures), 32'd6);

        // Study exit colliding with midnight day 4 -> 5
        run_until(NETFLIX, 478);
        step(STUDY, 1);
        step(EAT, 1);
        cmp("mid45_day", 32'(env.day), 32'd5);
        cmp("mid45_homework", 32'(env.homework), 32'd1);
        cmp("mid45_num_lectures", 32'(env.num_lectures), 32'd0);
        cmp("mid45_num_assignments", 32'(env.num_assignments), 32'd1);
        cmp("mid45_lecture", 32'(env.lecture), 32'd0);

        // Asynchronous reset mid-count
        step(GYM, 5);
        rst = 1'b1;
        model_reset();
        #2;
        chk_reset_vals("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        step(SLEEP, 10);
        cmp("post_reset_edges", 32'(env.hour), 32'd2);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
